calc_sevenseg_disp: RTL and testbench

Consumer side of the calculator's 16-bit LED/accumulator output. Takes the signed accumulator value and drives a time-multiplexed 4-digit common-anode seven-segment display in hex. Features: frame-synchronous snapshot (no tearing), anti-ghost guard blanking and optional leading-zero blanking. Sits beside the calculator core in the board top level, fed from the same `led` bus.

---
 rtl/calc_disp_pkg.sv | 26 ++
 rtl/hex_to_7seg.sv | 33 +++
 rtl/calc_sevenseg_disp.sv | 149 ++++++++++++++
 tb/tb_calc_sevenseg_disp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator seven-segment display path:
// active-low segment patterns ({g,f,e,d,c,b,a}) and default scan timing.
package calc_disp_pkg;

    localparam int DEF_REFRESH_DIV  = 100000;
    localparam int DEF_GUARD_CYCLES = 4;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
    import calc_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex digit.
    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/calc_sevenseg_disp.sv
// Time-multiplexed hex display of the calculator accumulator on a
// common-anode 4-digit seven-segment module.
//
// Scan FSM (state = digit index dig_q):
//   state       | meaning
//   0           | slot for LS nibble, anode bit 0
//   1..N-2      | slot for intermediate nibbles
//   N-1         | slot for MS nibble; its last cycle is the frame boundary
//
// Each slot lasts REFRESH_DIV cycles, timed by a down-counter that reloads
// at terminal count. The first GUARD_CYCLES of each slot keep all anodes
// off so the previous digit's segments never ghost onto the next anode.
// The value is captured once per frame so a digit update never tears.
module calc_sevenseg_disp
    import calc_disp_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_W-1:0]     value,
    input  logic                  lz_en,
    input  logic                  blank,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic                  frame_tick
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    // Counter runs REFRESH_DIV-1 down to 0, so elapsed slot time p = CNT_TOP - cnt.
    // p < GUARD_CYCLES is therefore cnt > GUARD_LIM.
    localparam logic [CW-1:0] CNT_TOP   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LIM = CW'(REFRESH_DIV - 1 - GUARD_CYCLES);
    localparam logic [DW-1:0] D_LAST    = DW'(NUM_DIGITS - 1);

    if (DATA_W != 4 * NUM_DIGITS) begin : g_bad_width
        $fatal(1, "calc_sevenseg_disp: DATA_W must equal 4*NUM_DIGITS");
    end
    if (REFRESH_DIV < GUARD_CYCLES + 2) begin : g_bad_div
        $fatal(1, "calc_sevenseg_disp: REFRESH_DIV must be >= GUARD_CYCLES+2");
    end

    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic [DW-1:0]         dig_q, dig_nxt;
    logic                  slot_end, frame_end, in_guard;
    logic [DATA_W-1:0]     snapshot_q;
    logic                  frame_tick_q;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  zero_run;
    logic                  lz_blank;
    logic [3:0]            nib;
    logic [6:0]            seg_dig;
    logic [NUM_DIGITS-1:0] an_q, an_nxt;
    logic [6:0]            seg_q, seg_nxt;
    logic                  dp_n_q, dp_n_nxt;

    // Slot timer and digit-index state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= CNT_TOP;
            dig_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            dig_q <= dig_nxt;
        end
    end

    // Next slot/digit: advance the digit when the slot timer hits terminal count.
    always_comb begin
        slot_end  = (cnt_q == '0);
        frame_end = slot_end && (dig_q == D_LAST);
        in_guard  = (cnt_q > GUARD_LIM);
        cnt_nxt   = cnt_q - 1'b1;
        dig_nxt   = dig_q;
        if (slot_end) begin
            cnt_nxt = CNT_TOP;
            dig_nxt = (dig_q == D_LAST) ? '0 : dig_q + 1'b1;
        end
    end

    // Capture the value at the frame boundary and flag the new frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snapshot_q   <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_end;
            if (frame_end) begin
                snapshot_q <= value;
            end
        end
    end

    // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 of the snapshot are all zero.
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (snapshot_q[4*i +: 4] == 4'h0);
            upper_zero[i] = zero_run;
        end
    end

    assign lz_blank = lz_en && (dig_q != '0) && upper_zero[dig_q];
    assign nib      = snapshot_q[4*dig_q +: 4];

    hex_to_7seg u_hex (
        .nib (nib),
        .seg (seg_dig)
    );

    // Drive pattern for the current slot; any blanking reason forces all-off.
    always_comb begin
        an_nxt   = '1;
        seg_nxt  = SEG_OFF;
        dp_n_nxt = 1'b1;
        if (!(blank || in_guard || lz_blank)) begin
            an_nxt[dig_q] = 1'b0;
            seg_nxt       = seg_dig;
            dp_n_nxt      = ~dp_mask[dig_q];
        end
    end

    // Registered pad drivers, one cycle behind the scan state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            an_q   <= '1;
            seg_q  <= SEG_OFF;
            dp_n_q <= 1'b1;
        end else begin
            an_q   <= an_nxt;
            seg_q  <= seg_nxt;
            dp_n_q <= dp_n_nxt;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_calc_sevenseg_disp.sv
// Scoreboard bench for calc_sevenseg_disp: a cycle-indexed reference model
// pushes the expected pad state for every clock, a monitor pops and compares.
module tb_calc_sevenseg_disp;

    localparam int R = 8;
    localparam int G = 2;
    localparam int N = 4;
    localparam int W = 16;
    localparam int FRAME = R * N;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic       tick;
    } exp_t;

    localparam exp_t RESET_EXP = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1, tick: 1'b0};

    logic         clk     = 1'b0;
    logic         resetn  = 1'b0;
    logic [W-1:0] value   = '0;
    logic         lz_en   = 1'b0;
    logic         blank   = 1'b0;
    logic [N-1:0] dp_mask = '0;
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp_n;
    logic         frame_tick;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    logic [6:0] hex7_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    calc_sevenseg_disp #(
        .DATA_W       (W),
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .GUARD_CYCLES (G)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .value      (value),
        .lz_en      (lz_en),
        .blank      (blank),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: t = clock edges since reset release; slot position is
    // plain arithmetic on t, the shown value changes only on frame boundaries.
    int           t = 0;
    logic [W-1:0] m_snap = '0;
    int           mp, md;
    logic [3:0]   m_nib;
    logic         m_lz;
    exp_t         me;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            t      = 0;
            m_snap = '0;
            exp_q.delete();
        end else begin
            mp    = t % R;
            md    = (t / R) % N;
            m_nib = 4'(m_snap >> (4 * md));
            m_lz  = lz_en && (md > 0) && ((m_snap >> (4 * md)) == 0);
            if (blank || (mp < G) || m_lz) begin
                me.an   = 4'hF;
                me.seg  = 7'h7F;
                me.dp_n = 1'b1;
            end else begin
                me.an   = ~(4'b0001 << md);
                me.seg  = hex7_tab[m_nib];
                me.dp_n = ~dp_mask[md];
            end
            me.tick = (((t + 1) % FRAME) == 0);
            exp_q.push_back(me);
            if (me.tick) m_snap = value;
            t++;
        end
    end

    // Monitor: compare pads against the oldest expectation, away from the active edge.
    exp_t mon_e;
    exp_t mon_a;
    always @(negedge clk) begin
        if (!resetn || exp_q.size() == 0) mon_e = RESET_EXP;
        else mon_e = exp_q.pop_front();
        mon_a = {an, seg, dp_n, frame_tick};
        checks++;
        if (mon_a !== mon_e) begin
            failures++;
            $display("FAIL pads t=%0d time=%0t got an=%h seg=%h dp_n=%b tick=%b want an=%h seg=%h dp_n=%b tick=%b",
                     t, $time, mon_a.an, mon_a.seg, mon_a.dp_n, mon_a.tick,
                     mon_e.an, mon_e.seg, mon_e.dp_n, mon_e.tick);
        end
        checks++;
        if ($countones(~an) > 1) begin
            failures++;
            $display("FAIL anode_onehot time=%0t got an=%b want at most one low", $time, an);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        checks++;
        if ({an, seg, dp_n, frame_tick} !== RESET_EXP) begin
            failures++;
            $display("FAIL async_reset got an=%h seg=%h dp_n=%b tick=%b want an=f seg=7f dp_n=1 tick=0",
                     an, seg, dp_n, frame_tick);
        end
        cyc(2);
        #2 resetn = 1'b1;
    endtask

    // Wait until the model says the scan is in slot d at position p (bounded).
    task automatic wait_pos(input int d, input int p);
        int guard_cnt;
        guard_cnt = 0;
        while (!(((t / R) % N) == d && (t % R) == p) && guard_cnt < 4 * FRAME) begin
            @(negedge clk);
            guard_cnt++;
        end
        checks++;
        if (guard_cnt >= 4 * FRAME) begin
            failures++;
            $display("FAIL wait_pos timeout got t=%0d want slot %0d pos %0d", t, d, p);
        end
    endtask

    initial begin
        // Reset, then first frame with lz off shows "0000" from the reset snapshot.
        cyc(3);
        #2 resetn = 1'b1;
        value = 16'h1A3F;
        cyc(2 * FRAME + 5);
        // Asynchronous reset mid-scan; after release the zero snapshot with lz on.
        do_reset();
        lz_en = 1'b1;
        cyc(FRAME + 3);
        // Held value, full digits.
        lz_en = 1'b0;
        value = 16'h1A3F;
        cyc(3 * FRAME);
        // Leading-zero blanking.
        lz_en = 1'b1;
        value = 16'h0042;
        cyc(2 * FRAME);
        value = 16'h0000;
        cyc(2 * FRAME);
        // Mid-frame value change must not tear.
        lz_en = 1'b0;
        value = 16'h1111;
        cyc(2 * FRAME);
        wait_pos(1, 3);
        value = 16'h2222;
        cyc(2 * FRAME);
        // Blank pulse inside a lit slot.
        value = 16'h5A5A;
        cyc(FRAME);
        wait_pos(2, 4);
        blank = 1'b1;
        cyc(3);
        blank = 1'b0;
        cyc(FRAME);
        // Decimal point on digit 2 only.
        dp_mask = 4'b0100;
        value   = 16'h1234;
        cyc(2 * FRAME);
        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: value = 16'($urandom_range(0, 15));
                1: value = 16'($urandom_range(0, 255));
                2: value = 16'($urandom_range(0, 4095));
                default: value = 16'($urandom);
            endcase
            lz_en   = ($urandom_range(0, 1) == 1);
            dp_mask = 4'($urandom);
            blank   = ($urandom_range(0, 7) == 0);
            cyc($urandom_range(1, 3));
            blank = 1'b0;
            if ($urandom_range(0, 19) == 0) do_reset();
            cyc($urandom_range(1, 40));
        end
        cyc(FRAME);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
